// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned MULT_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/adder_32b.sv
// 32-bit ripple-carry adder; the multiplier's only arithmetic resource.
module adder_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  logic [32:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = carry_in;
    for (int unsigned i = 0; i < 32; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    carry_out = carry[32];
  end

endmodule

// File: rtl/mult_32b_seq.sv
// Sequential unsigned 32x32->64 multiplier: one partial-product bit per clock
// through adder_32b, with valid/ready handshakes on both sides.
module mult_32b_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  mult_state_t       state, state_nxt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  acc_lo;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  addend;
  logic [WIDTH-1:0]  sum;
  logic              carry_out;
  logic              accept;
  logic              last;

  assign addend = acc_lo[0] ? mcand : '0;

  adder_32b u_adder (
    .a         (acc_hi),
    .b         (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {acc_hi, acc_lo};
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST_ITER);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // 65-bit right shift of {carry_out, sum, acc_lo}: the adder carry lands in acc_hi[31].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc_hi <= {carry_out, sum[WIDTH-1:1]};
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_32b_seq.sv
// Scoreboard bench for mult_32b_seq: directed operand pairs with hand-computed products.
module tb_mult_32b_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mult_32b_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", product, 64'hx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("product", product, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns after the accept edge + 1.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] exp);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      step();
      g++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    a_i = ta;
    b_i = tb;
    exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid; optionally disturbs inputs during RUN.
  task automatic wait_out(input bit disturb);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      if (disturb && n < 20) begin
        in_valid = n[0];
        a_i = $urandom;
        b_i = $urandom;
        chk("in_ready_in_run", {63'd0, in_ready}, 64'd0);
      end else begin
        in_valid = 1'b0;
      end
      step();
      n++;
    end
    chk("latency", 64'(n), 64'd32);
  endtask

  task automatic drain_check();
    step();
    chk("in_ready_after_done", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_done", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_product", product, 64'd0);

    launch(32'd3, 32'd5, 64'd15);
    wait_out(1'b0);
    drain_check();

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    wait_out(1'b0);
    drain_check();

    launch(32'h12345678, 32'h0, 64'd0);
    wait_out(1'b1);
    drain_check();

    launch(32'h0, 32'hDEADBEEF, 64'd0);
    wait_out(1'b1);
    drain_check();

    // Back-pressure: hold the result for 10 cycles.
    out_ready = 1'b0;
    launch(32'h80000000, 32'd2, 64'h100000000);
    wait_out(1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_product", product, 64'h100000000);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    drain_check();

    // Reset in the middle of a computation discards it.
    in_valid = 1'b1;
    a_i = 32'd7;
    b_i = 32'd9;
    step();
    in_valid = 1'b0;
    repeat (16) step();
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_product", product, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) chk("midrst_no_output", {63'd0, out_valid}, 64'd0);
      step();
    end
    chk("midrst_idle", {63'd0, in_ready}, 64'd1);

    launch(32'd7, 32'd9, 64'd63);
    wait_out(1'b0);
    drain_check();

    repeat (3) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
